// File: rtl/abus_arbiter.sv
// abus_arbiter: registered round-robin arbiter for the 19-bit A bus.
// Each requester offers a 4-bit A-bus source select (0=DMAR, 1=DMDR,
// 2..13=R0..R11) and may lock the bus for up to MAX_LOCK consecutive
// cycles. The mux select, one-hot grant, owner and valid flag are all
// registered, so there is no combinational path from inputs to outputs.
module abus_arbiter #(
  parameter int NREQ     = 4,
  parameter int OWN_W    = 2,
  parameter int MAX_LOCK = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [4*NREQ-1:0]    sel_flat,
  input  logic [NREQ-1:0]      lock,
  output logic [NREQ-1:0]      gnt,
  output logic [3:0]           a_sel,
  output logic                 a_valid,
  output logic [OWN_W-1:0]     owner,
  output logic                 sel_err,
  output logic                 lock_to
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LOCK);
  localparam logic [OWN_W-1:0] LAST_IDX = OWN_W'(NREQ - 1);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t            state;
  logic [OWN_W-1:0]  ptr;
  logic [CNT_W-1:0]  cnt;

  logic [3:0]        sel_arr [NREQ];
  logic [NREQ-1:0]   sel_ok;
  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   excl;
  logic [NREQ-1:0]   cand;
  logic              hold;
  logic              hold_last;
  logic              timeout;
  logic              found;
  logic [OWN_W-1:0]  win;
  int                idx;

  // Split the flat select bus and flag requesters that may compete this cycle.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      sel_arr[i] = sel_flat[4*i +: 4];
      sel_ok[i]  = (sel_flat[4*i +: 4] <= 4'd13);
    end
    eligible = req & sel_ok;
  end

  // While locked, decide whether the owner keeps the bus or must release it,
  // and which requester is excluded from the re-arbitration on this edge.
  always_comb begin
    hold      = 1'b0;
    hold_last = 1'b0;
    timeout   = 1'b0;
    excl      = '0;
    if (state == LOCKED) begin
      if (!req[owner]) begin
        hold = 1'b0;
      end else if (!sel_ok[owner]) begin
        excl[owner] = 1'b1;
      end else if (cnt == CNT_MAX) begin
        timeout     = 1'b1;
        excl[owner] = 1'b1;
      end else begin
        hold      = 1'b1;
        hold_last = !lock[owner];
      end
    end
    cand = eligible & ~excl;
  end

  // Round-robin search: first candidate at or after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx[OWN_W-1:0];
      end
    end
  end

  // Grant register, priority pointer, lock counter and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB;
      ptr     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      a_sel   <= 4'b0000;
      a_valid <= 1'b0;
      owner   <= '0;
      sel_err <= 1'b0;
      lock_to <= 1'b0;
    end else begin
      sel_err <= |(req & ~sel_ok);
      lock_to <= timeout;
      if (hold) begin
        a_sel <= sel_arr[owner];
        cnt   <= cnt + 1'b1;
        state <= hold_last ? ARB : LOCKED;
      end else if (found) begin
        gnt     <= NREQ'(1) << win;
        a_sel   <= sel_arr[win];
        owner   <= win;
        a_valid <= 1'b1;
        ptr     <= (win == LAST_IDX) ? '0 : win + 1'b1;
        cnt     <= CNT_W'(1);
        state   <= lock[win] ? LOCKED : ARB;
      end else begin
        gnt     <= '0;
        a_valid <= 1'b0;
        state   <= ARB;
      end
    end
  end

endmodule

// File: tb/tb_abus_arbiter.sv
// tb_abus_arbiter: directed vector table for the documented scenarios,
// then a long randomized run compared against a behavioural model.
module tb_abus_arbiter;

  localparam int NREQ     = 4;
  localparam int OWN_W    = 2;
  localparam int MAX_LOCK = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] sel_flat;
  logic [3:0]  lock;
  logic [3:0]  gnt;
  logic [3:0]  a_sel;
  logic        a_valid;
  logic [1:0]  owner;
  logic        sel_err;
  logic        lock_to;

  int total = 0;
  int bad   = 0;

  abus_arbiter #(.NREQ(NREQ), .OWN_W(OWN_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .sel_flat (sel_flat),
    .lock     (lock),
    .gnt      (gnt),
    .a_sel    (a_sel),
    .a_valid  (a_valid),
    .owner    (owner),
    .sel_err  (sel_err),
    .lock_to  (lock_to)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    bit        rst;
    bit [3:0]  req;
    bit [15:0] sel;
    bit [3:0]  lock;
    bit [3:0]  gnt;
    bit [3:0]  asel;
    bit        valid;
    bit [1:0]  own;
    bit        err;
    bit        to;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state: plain integers describing who holds the bus.
  bit       m_locked;
  int       m_owner;
  int       m_cnt;
  int       m_ptr;
  bit [3:0] e_gnt;
  bit [3:0] e_asel;
  bit       e_valid;
  int       e_owner;
  bit       e_err;
  bit       e_to;

  function automatic int nib(input bit [15:0] s, input int i);
    return int'(s[4*i +: 4]);
  endfunction

  function automatic vec_t mk(input bit r, input bit [3:0] rq, input bit [15:0] s,
                              input bit [3:0] lk, input bit [3:0] g, input bit [3:0] as,
                              input bit v, input bit [1:0] o, input bit er, input bit t);
    vec_t x;
    x.rst = r; x.req = rq; x.sel = s; x.lock = lk; x.gnt = g; x.asel = as;
    x.valid = v; x.own = o; x.err = er; x.to = t;
    return x;
  endfunction

  task automatic modelStep(input bit r, input bit [3:0] rq, input bit [15:0] s, input bit [3:0] lk);
    int  excluded;
    bit  do_arb;
    int  w;
    if (r) begin
      m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      e_gnt = 0; e_asel = 0; e_valid = 0; e_owner = 0; e_err = 0; e_to = 0;
      return;
    end
    e_err = 0;
    for (int i = 0; i < NREQ; i++)
      if (rq[i] && nib(s, i) > 13) e_err = 1;
    e_to = 0;
    excluded = -1;
    do_arb = 1;
    if (m_locked) begin
      if (!rq[m_owner]) begin
        do_arb = 1;
      end else if (nib(s, m_owner) > 13) begin
        excluded = m_owner;
      end else if (m_cnt == MAX_LOCK) begin
        e_to = 1;
        excluded = m_owner;
      end else begin
        do_arb = 0;
        e_asel = 4'(nib(s, m_owner));
        m_cnt = m_cnt + 1;
        m_locked = lk[m_owner];
      end
    end
    if (do_arb) begin
      m_locked = 0;
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (w < 0 && rq[i] && nib(s, i) <= 13 && i != excluded) w = i;
      end
      if (w >= 0) begin
        e_gnt = 4'(1 << w);
        e_asel = 4'(nib(s, w));
        e_valid = 1;
        e_owner = w;
        m_owner = w;
        m_ptr = (w + 1) % NREQ;
        m_cnt = 1;
        m_locked = lk[w];
      end else begin
        e_gnt = 0;
        e_valid = 0;
      end
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, settle.
  task automatic applyStimulus(input bit r, input bit [3:0] rq, input bit [15:0] s, input bit [3:0] lk);
    @(negedge clk);
    rst = r; req = rq; sel_flat = s; lock = lk;
    @(posedge clk);
    modelStep(r, rq, s, lk);
    #1;
  endtask

  initial begin
    bit [3:0]  r_req;
    bit [15:0] r_sel;
    bit [3:0]  r_lock;
    bit        r_rst;

    rst = 1'b1; req = '0; sel_flat = '0; lock = '0;

    // Reset with everyone requesting.
    tbl.push_back(mk(1, 4'hF, 16'hD523, 4'h0, 4'b0000, 4'd0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 16'hD523, 4'h0, 4'b0000, 4'd0, 0, 0, 0, 0));
    // Round robin, sel 3,2,5,13.
    tbl.push_back(mk(0, 4'hF, 16'hD523, 4'h0, 4'b0001, 4'd3,  1, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 16'hD523, 4'h0, 4'b0010, 4'd2,  1, 1, 0, 0));
    tbl.push_back(mk(0, 4'hF, 16'hD523, 4'h0, 4'b0100, 4'd5,  1, 2, 0, 0));
    tbl.push_back(mk(0, 4'hF, 16'hD523, 4'h0, 4'b1000, 4'd13, 1, 3, 0, 0));
    tbl.push_back(mk(0, 4'hF, 16'hD523, 4'h0, 4'b0001, 4'd3,  1, 0, 0, 0));
    // Requester 1 locks on DMDR while requester 0 waits.
    tbl.push_back(mk(0, 4'h3, 16'h0013, 4'h2, 4'b0010, 4'd1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h3, 16'h0013, 4'h2, 4'b0010, 4'd1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h3, 16'h0013, 4'h2, 4'b0010, 4'd1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h3, 16'h0013, 4'h0, 4'b0010, 4'd1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h3, 16'h0013, 4'h0, 4'b0001, 4'd3, 1, 0, 0, 0));
    // Requester 2 locks forever, requester 3 waits: 8 cycles then timeout.
    for (int i = 0; i < MAX_LOCK; i++)
      tbl.push_back(mk(0, 4'hC, 16'hD500, 4'h4, 4'b0100, 4'd5, 1, 2, 0, 0));
    tbl.push_back(mk(0, 4'hC, 16'hD500, 4'h4, 4'b1000, 4'd13, 1, 3, 0, 1));
    tbl.push_back(mk(0, 4'hC, 16'hD500, 4'h4, 4'b0100, 4'd5,  1, 2, 0, 0));
    // Invalid select on requester 0 (14) while requester 1 asks with 6.
    tbl.push_back(mk(0, 4'h3, 16'h006E, 4'h0, 4'b0010, 4'd6, 1, 1, 1, 0));
    tbl.push_back(mk(0, 4'h3, 16'h006E, 4'h0, 4'b0010, 4'd6, 1, 1, 1, 0));
    // Reset in the middle of a lock held by requester 3.
    tbl.push_back(mk(0, 4'h8, 16'h7000, 4'h8, 4'b1000, 4'd7, 1, 3, 0, 0));
    tbl.push_back(mk(0, 4'h8, 16'h7000, 4'h8, 4'b1000, 4'd7, 1, 3, 0, 0));
    tbl.push_back(mk(1, 4'h8, 16'h7000, 4'h8, 4'b0000, 4'd0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h9, 16'h7003, 4'h8, 4'b0001, 4'd3, 1, 0, 0, 0));
    // Nobody requesting: grant drops, select holds.
    tbl.push_back(mk(0, 4'h0, 16'h7003, 4'h0, 4'b0000, 4'd3, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst, tbl[i].req, tbl[i].sel, tbl[i].lock);
      checkOutput($sformatf("vec%0d gnt", i),     int'(gnt),     int'(tbl[i].gnt));
      checkOutput($sformatf("vec%0d a_sel", i),   int'(a_sel),   int'(tbl[i].asel));
      checkOutput($sformatf("vec%0d a_valid", i), int'(a_valid), int'(tbl[i].valid));
      checkOutput($sformatf("vec%0d sel_err", i), int'(sel_err), int'(tbl[i].err));
      checkOutput($sformatf("vec%0d lock_to", i), int'(lock_to), int'(tbl[i].to));
      if (tbl[i].valid)
        checkOutput($sformatf("vec%0d owner", i), int'(owner), int'(tbl[i].own));
    end

    // Randomized run with sticky inputs so locks survive long enough to time out.
    r_req = '0; r_sel = 16'h3210; r_lock = '0;
    applyStimulus(1, r_req, r_sel, r_lock);
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) r_req[i] = ~r_req[i];
        if ($urandom_range(0, 5) == 0) r_lock[i] = ~r_lock[i];
        if ($urandom_range(0, 5) == 0)
          r_sel[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(14, 15))
                                                         : 4'($urandom_range(0, 13));
      end
      applyStimulus(r_rst, r_req, r_sel, r_lock);
      checkOutput("rand gnt",     int'(gnt),     int'(e_gnt));
      checkOutput("rand a_sel",   int'(a_sel),   int'(e_asel));
      checkOutput("rand a_valid", int'(a_valid), int'(e_valid));
      checkOutput("rand sel_err", int'(sel_err), int'(e_err));
      checkOutput("rand lock_to", int'(lock_to), int'(e_to));
      if (e_valid)
        checkOutput("rand owner", int'(owner), e_owner);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/abus_arbiter.md
Name: abus_arbiter

Overview:
Registered round-robin arbiter that shares the 19-bit A bus among NREQ requesters (e.g. ALU sequencer, memory/DMDR path, downsample address unit, debug port). Each requester presents a 4-bit A-bus source select and may hold the bus with a lock. The arbiter drives the A-bus mux select (0=DMAR, 1=DMDR, 2..13=R0..R11) plus a one-hot grant and valid flag. It sits between the requesting control units and the A-bus mux.

Parameters:
NREQ, 4, number of requesters (2..8)
OWN_W, 2, width of owner index, equals ceil(log2(NREQ))
MAX_LOCK, 8, max consecutive granted cycles for one locked owner before forced release (>=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req  input  NREQ  per-requester bus request, level
sel_flat  input  4*NREQ  requester i source select at bits [4i+3:4i]
lock  input  NREQ  requester i asks to keep bus after current grant
gnt  output  NREQ  one-hot grant, registered
a_sel  output  4  A-bus mux select, registered
a_valid  output  1  a_sel belongs to a granted transfer this cycle
owner  output  OWN_W  index of granted requester (valid when a_valid=1)
sel_err  output  1  one-cycle pulse: a requester presented select >13
lock_to  output  1  one-cycle pulse: lock forcibly released at MAX_LOCK

Behaviour:
- Reset (rst=1 at clk edge, overrides everything, including mid-lock): gnt=0, a_sel=4'b0000, a_valid=0, owner=0, sel_err=0, lock_to=0, priority pointer ptr=0, lock counter=0, state=ARB.
- Valid select: sel<=13. Eligible requester i: req[i]=1 and sel_i valid.
- Latency: decision made from inputs sampled at edge N; gnt/a_sel/a_valid/owner update at edge N, visible during cycle N+1. Combinational path input->output not permitted.
- State ARB:
  - No eligible requester: gnt=0, a_valid=0, a_sel holds last value, ptr unchanged.
  - Else winner = first eligible at or after ptr, wrapping modulo NREQ. gnt=onehot(winner), a_sel=sel_winner, owner=winner, a_valid=1, ptr=(winner+1) mod NREQ, lock counter=1.
  - If lock[winner]=1 at the same edge -> LOCKED, else stay ARB (grant lasts exactly one cycle).
- State LOCKED (owner o):
  - req[o]=1, lock[o]=1, sel_o valid, counter<MAX_LOCK: keep gnt/owner, a_sel=sel_o (updates every cycle), a_valid=1, counter+1.
  - lock[o]=0 with req[o]=1 and valid sel: final granted cycle with a_sel=sel_o, then ARB.
  - req[o]=0: release immediately; this edge performs a normal ARB decision among others (no dead cycle).
  - counter=MAX_LOCK: lock_to=1 for one cycle, release, normal ARB decision this edge with o excluded for this decision only. Thus owner holds at most MAX_LOCK consecutive cycles.
  - sel_o invalid: sel_err=1, release, ARB decision this edge excluding o.
- sel_err: asserted (registered, one cycle) whenever any requester has req=1 with sel>13 at the edge; such requesters never granted. Continuous invalid request -> sel_err stays high each cycle.
- Simultaneous requests: exactly one gnt bit; fairness: each continuously eligible requester granted within NREQ arbitration decisions.
- lock[i] from non-winning or non-owner requesters ignored.
- gnt is always one-hot or zero; a_valid=1 iff gnt!=0.

Test Plan:
- Reset: assert rst 2 cycles with req=4'b1111 -> gnt=0, a_sel=0, a_valid=0, sel_err=0; first grant after release goes to requester 0.
- Round-robin: req=4'b1111, sel=3,2,5,13 for req0..3, no lock -> gnt sequence 0001,0010,0100,1000,0001; a_sel 3,2,5,13,3; owner 0,1,2,3,0.
- Lock: req1 holds lock with sel=1 (DMDR) while req0 also requests -> gnt=0010 for 3 cycles while lock=1; lock dropped -> one more cycle, then gnt=0001.
- Lock timeout: MAX_LOCK=8, req2 locks forever, req3 requests -> gnt=0100 exactly 8 cycles, lock_to=1 one cycle, next gnt=1000.
- Invalid select: req0 sel=14, req1 sel=6 -> sel_err=1, gnt=0010, a_sel=6; req0 never granted.
- Reset mid-lock: rst during LOCKED by req3 -> next cycle gnt=0, a_valid=0, ptr=0; after release req0 and req3 requesting -> gnt=0001.
